inst_mem_ctrl: RTL and testbench

Memory-side responder for the fetch/load-store request interface. Accepts a level-held `mem_request` with `we_re`, `mask` and address, waits a configurable number of cycles, then performs one word read or byte-masked write on an internal synchronous RAM and pulses `valid` for one cycle. It sits between the core's fetch or data port and the backing memory; the requester stalls on `!valid`.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_array.sv | 34 +++
 rtl/inst_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_inst_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for inst_mem_ctrl and its RAM.
package mem_pkg;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned DEFAULT_LATENCY = 2;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BYTES_W         = 4;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Which source currently drives data_out.
  typedef enum logic [1:0] {
    DSRC_ZERO = 2'd0,
    DSRC_RAM  = 2'd1,
    DSRC_NOP  = 2'd2
  } dsrc_t;

  // Request payload captured on acceptance (address index kept separately).
  typedef struct packed {
    logic                 we;
    logic [BYTES_W-1:0]   mask;
    logic [WORD_W-1:0]    wdata;
  } req_t;

  // Counter preload: the access happens LATENCY edges after acceptance.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: synchronous single-port byte-writable RAM.
// A cycle with en=1 and we=0000 is a read; any set we bit makes it a write.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BYTES_W-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Word read into the output register, or byte-lane write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we == '0) r_rdata <= r_mem[addr];
      for (int b = 0; b < BYTES_W; b++) begin
        if (we[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: memory-side responder for the fetch/load-store request port.
// Accepts a held request, waits LATENCY cycles, performs one word read or
// byte-masked write and pulses valid for one cycle. Back-to-back requests are
// accepted in the response cycle.
// Optional feature macro: INST_MEM_ERR_EN (adds err output; misaligned or
// out-of-range addresses suppress writes and read back NOP_INSTR).
module inst_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = DEFAULT_LATENCY,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        valid,
  output logic [31:0] data_out,
  output logic        busy
`ifdef INST_MEM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned IDX_LSB = 2;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  req_t                    r_req;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic                    r_valid;
  logic                    r_busy;
  dsrc_t                   r_dsrc;

  logic                    w_accept;
  logic                    w_access;
  logic                    w_bad;
  logic                    w_ram_en;
  logic [BYTES_W-1:0]      w_ram_we;
  logic [WORD_W-1:0]       w_rdata;

  assign w_accept = mem_request && ((r_state == ST_IDLE) || (r_state == ST_RESP));
  assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);

`ifdef INST_MEM_ERR_EN
  logic r_err_pend;
  logic r_err;
  logic w_addr_bad;

  assign w_addr_bad = (address[1:0] != 2'b00) ||
                      ((address >> (ADDR_WIDTH + IDX_LSB)) != 32'd0);
  assign w_bad      = r_err_pend;
  assign err        = r_err;

  // Classify the address at acceptance so the access edge only sees a flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_err_pend <= 1'b0;
    else if (w_accept) r_err_pend <= w_addr_bad;
  end
`else
  logic w_unused_addr;

  // Alignment and upper address bits are deliberately ignored (wrap mode).
  assign w_unused_addr = ^{address[1:0], address >> (ADDR_WIDTH + IDX_LSB)};
  assign w_bad         = 1'b0;
`endif

  // A zero-mask write touches nothing, so the RAM is left idle for it.
  assign w_ram_we = r_req.we ? r_req.mask : '0;
  assign w_ram_en = w_access && !w_bad && (!r_req.we || (r_req.mask != '0));

  // Capture the request payload; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_req.we    <= we_re;
      r_req.mask  <= mask;
      r_req.wdata <= data_in;
      r_idx       <= address[ADDR_WIDTH+1:IDX_LSB];
    end
  end

  // Request/wait/response sequencing with registered valid, busy and err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_dsrc  <= DSRC_ZERO;
`ifdef INST_MEM_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef INST_MEM_ERR_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_accept) begin
            r_state <= ST_WAIT;
            r_cnt   <= cnt_load(LATENCY);
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RESP;
            r_valid <= 1'b1;
            if (!r_req.we) r_dsrc <= w_bad ? DSRC_NOP : DSRC_RAM;
`ifdef INST_MEM_ERR_EN
            r_err   <= w_bad;
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Select the held read result (RAM output register, NOP, or reset zero).
  always_comb begin
    data_out = '0;
    case (r_dsrc)
      DSRC_RAM: data_out = w_rdata;
      DSRC_NOP: data_out = NOP_INSTR;
      default:  data_out = '0;
    endcase
  end

  assign valid = r_valid;
  assign busy  = r_busy;

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_ram_we),
    .addr  (r_idx),
    .wdata (r_req.wdata),
    .rdata (w_rdata)
  );

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl: transaction-level memory model,
// per-cycle output comparison, directed cases and randomized traffic.
module tb_inst_mem_ctrl;

  localparam int unsigned AW    = 10;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_request = 1'b0;
  logic        we_re = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic        valid;
  logic [31:0] data_out;
  logic        busy;
`ifdef INST_MEM_ERR_EN
  logic        err;
  logic        exp_err = 1'b0;
  logic        resp_err;
`endif

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_busy = 1'b0;
  logic [31:0] exp_dout = 32'h0;
  logic        prev_valid = 1'b0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] got;

  always #5 clk = ~clk;

  inst_mem_ctrl #(
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_request (mem_request),
    .we_re       (we_re),
    .mask        (mask),
    .address     (address),
    .data_in     (data_in),
    .valid       (valid),
    .data_out    (data_out),
    .busy        (busy)
`ifdef INST_MEM_ERR_EN
    ,
    .err         (err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
`ifdef INST_MEM_ERR_EN
    return (a % 4 != 0) || (a / (4 * DEPTH) != 0);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Per-cycle comparison of every output against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_busy));
      check("data_out", data_out, exp_dout);
`ifdef INST_MEM_ERR_EN
      check("err", 32'(err), 32'(exp_err));
`endif
      check("valid_adjacent", 32'(prev_valid & valid), 32'h0);
      prev_valid = valid;
    end
  end

  // One transaction starting just after an edge with the DUT idle or responding.
  // Returns the data_out and valid seen in the response cycle.
  task automatic run_txn(input bit we, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] d, input bit keep,
                         output logic [31:0] rdout, output logic rvalid);
    bit e;
    we_re = we; mask = m; address = a; data_in = d; mem_request = 1'b1;
    @(posedge clk); #1;
    exp_valid = 1'b0; exp_busy = 1'b1;
`ifdef INST_MEM_ERR_EN
    exp_err = 1'b0;
`endif
    we_re = 1'($urandom); mask = 4'($urandom); address = $urandom; data_in = $urandom;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    e = addr_err(a);
    if (we && !e) model_mem[widx(a)] = merge(model_mem[widx(a)], d, m);
    if (!we) exp_dout = e ? 32'h0000_0013 : model_mem[widx(a)];
    exp_valid = 1'b1;
`ifdef INST_MEM_ERR_EN
    exp_err  = e;
    resp_err = err;
`endif
    rdout  = data_out;
    rvalid = valid;
    if (!keep) begin
      mem_request = 1'b0;
      @(posedge clk); #1;
      exp_valid = 1'b0; exp_busy = 1'b0;
`ifdef INST_MEM_ERR_EN
      exp_err = 1'b0;
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic        rv;
    logic [31:0] a;
    int unsigned idx;
    bit          keep;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_dout", data_out, 32'h0);
    chk_en = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single read at 0x8 (word 2 preloaded with DEADBEEF).
    run_txn(1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF, 1'b0, got, rv);
    run_txn(1'b0, 4'h0, 32'h8, 32'h0, 1'b0, got, rv);
    check("rd8_valid", 32'(rv), 32'h1);
    check("rd8_data", got, 32'hDEAD_BEEF);

    // Byte-masked write over AABBCCDD.
    run_txn(1'b1, 4'hF, 32'h10, 32'hAABB_CCDD, 1'b0, got, rv);
    run_txn(1'b1, 4'b0101, 32'h10, 32'h1122_3344, 1'b0, got, rv);
    check("mwr_valid", 32'(rv), 32'h1);
    check("mwr_dout_held", got, 32'hDEAD_BEEF);
    run_txn(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, got, rv);
    check("mask_merge", got, 32'hAA22_CC44);

    // Zero-mask write acknowledges but changes nothing.
    run_txn(1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 1'b0, got, rv);
    check("zmask_valid", 32'(rv), 32'h1);
    run_txn(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, got, rv);
    check("zmask_data", got, 32'hAA22_CC44);

    // Four back-to-back transactions with request held.
    run_txn(1'b1, 4'hF, 32'h40, 32'h0102_0304, 1'b1, got, rv);
    run_txn(1'b0, 4'h0, 32'h40, 32'h0, 1'b1, got, rv);
    check("b2b_rd", got, 32'h0102_0304);
    run_txn(1'b1, 4'b1000, 32'h40, 32'hEE00_0000, 1'b1, got, rv);
    run_txn(1'b0, 4'h0, 32'h40, 32'h0, 1'b0, got, rv);
    check("b2b_rd2", got, 32'hEE02_0304);

    // Address aliasing onto word 0x3FF.
    run_txn(1'b1, 4'hF, 32'h0000_0FFC, 32'h1234_5678, 1'b0, got, rv);
    run_txn(1'b1, 4'hF, 32'h0000_0FFC + 4 * DEPTH, 32'hCAFE_F00D, 1'b0, got, rv);
    run_txn(1'b0, 4'h0, 32'h0000_0FFC + 4 * DEPTH, 32'h0, 1'b0, got, rv);
`ifdef INST_MEM_ERR_EN
    check("alias_err", 32'(resp_err), 32'h1);
    check("alias_nop", got, 32'h0000_0013);
    run_txn(1'b0, 4'h0, 32'h0000_0FFC, 32'h0, 1'b0, got, rv);
    check("alias_wr_suppressed", got, 32'h1234_5678);
`else
    check("alias_rd", got, 32'hCAFE_F00D);
    run_txn(1'b0, 4'h0, 32'h0000_0FFC, 32'h0, 1'b0, got, rv);
    check("alias_rd_base", got, 32'hCAFE_F00D);
`endif

    // Reset during the wait of a write: write is dropped.
    run_txn(1'b1, 4'hF, 32'h20, 32'h0BAD_F00D, 1'b0, got, rv);
    we_re = 1'b1; mask = 4'hF; address = 32'h20; data_in = 32'h5555_5555; mem_request = 1'b1;
    @(posedge clk); #1;
    exp_busy = 1'b1; exp_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dout", data_out, 32'h0);
    exp_busy = 1'b0; exp_valid = 1'b0; exp_dout = 32'h0;
    mem_request = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    run_txn(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, got, rv);
    check("rst_drop_write", got, 32'h0BAD_F00D);

    // Randomized traffic over a preloaded pool of words.
    for (int i = 0; i <= 16; i++) begin
      idx = (i < 16) ? 32'(i) : DEPTH - 1;
      run_txn(1'b1, 4'hF, 32'(idx * 4), $urandom, 1'b0, got, rv);
    end
    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(16);
      if (idx == 16) idx = DEPTH - 1;
      a = 32'(idx * 4);
      if ($urandom_range(3) == 0) a = a | 32'($urandom_range(3));
      if ($urandom_range(3) == 0) a = a | ($urandom << (AW + 2));
      keep = (n != 149) && ($urandom_range(1) == 1);
      run_txn(1'($urandom), 4'($urandom), a, $urandom, keep, got, rv);
      if (!keep) repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
